// File: rtl/ahb_master_req_ctrl_if.sv
// Command and AHB bus-request signal bundle for ahb_master_req_ctrl.
// The master modport is the controller's view; the slave modport is the core/arbiter side.
interface ahb_master_req_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_write;
  logic [2:0]        cmd_size;
  logic [2:0]        cmd_burst;
  logic [3:0]        cmd_len;

  logic              hreq;
  logic              hgrant;
  logic              hwait;
  logic [1:0]        htrans;
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;

  logic              beat_done;
  logic [3:0]        beat_idx;
  logic              xfer_done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_burst, cmd_len,
    input  hgrant, hwait,
    output cmd_ready, hreq, htrans, haddr, hwrite, hsize, hburst,
    output beat_done, beat_idx, xfer_done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_burst, cmd_len,
    output hgrant, hwait,
    input  cmd_ready, hreq, htrans, haddr, hwrite, hsize, hburst,
    input  beat_done, beat_idx, xfer_done
  );
endinterface

// File: rtl/ahb_master_req_ctrl.sv
// Requester side of the AHB arbiter handshake: one burst command at a time, beat-by-beat
// address phases and data-phase completion tracking. Optional macro: EARLY_BURST_TERM_EN.
module ahb_master_req_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int MAX_INCR_LEN = 16
) (
  input logic                   hclk,
  input logic                   hreset,
  ahb_master_req_ctrl_if.master bus
);

  localparam logic [1:0] HT_IDLE   = 2'd0;
  localparam logic [1:0] HT_NONSEQ = 2'd2;
  localparam logic [1:0] HT_SEQ    = 2'd3;
  localparam logic [2:0] HB_SINGLE = 3'd0;
  localparam logic [2:0] HB_INCR   = 3'd1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ADDR, S_DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_r;
  logic              write_r;
  logic [2:0]        size_r;
  logic [2:0]        burst_r;
  logic [3:0]        last_r;
  logic [3:0]        addr_cnt;
  logic [3:0]        data_cnt;
  logic              pend;

  logic              cmd_ready_q;
  logic              hreq_q;
  logic [1:0]        htrans_q;
  logic [ADDR_W-1:0] haddr_q;
  logic              hwrite_q;
  logic [2:0]        hsize_q;
  logic [2:0]        hburst_q;
  logic              beat_done_q;
  logic [3:0]        beat_idx_q;
  logic              xfer_done_q;

`ifdef EARLY_BURST_TERM_EN
  logic              restart;
`endif

  logic accept;
  logic complete;

  // hgrant already carries ~hwait, so a presented address is taken whenever it is high.
  assign accept   = (state == S_ADDR) && bus.hgrant;
  assign complete = pend && !bus.hwait;

  function automatic logic [3:0] last_beat(input logic [2:0] burst, input logic [3:0] len);
    case (burst)
      3'd0:       last_beat = 4'd0;
      3'd1:       last_beat = (int'({28'd0, len}) + 1 > MAX_INCR_LEN) ? 4'(MAX_INCR_LEN - 1) : len;
      3'd2, 3'd3: last_beat = 4'd3;
      3'd4, 3'd5: last_beat = 4'd7;
      default:    last_beat = 4'd15;
    endcase
  endfunction

  // Wrapping bursts keep the high bits of the wrap block; INCR uses an all-ones mask.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0]        size,
                                                  input logic [2:0]        burst);
    logic [ADDR_W-1:0] bytes;
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] mask;
    bytes = ADDR_W'(1) << size;
    inc   = a + bytes;
    case (burst)
      3'd2:    mask = (bytes << 2) - ADDR_W'(1);
      3'd4:    mask = (bytes << 3) - ADDR_W'(1);
      3'd6:    mask = (bytes << 4) - ADDR_W'(1);
      default: mask = '1;
    endcase
    next_addr = (a & ~mask) | (inc & mask);
  endfunction

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state       <= S_IDLE;
      cmd_ready_q <= 1'b1;
      hreq_q      <= 1'b0;
      htrans_q    <= HT_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'd0;
      hburst_q    <= HB_SINGLE;
      beat_done_q <= 1'b0;
      beat_idx_q  <= 4'd0;
      xfer_done_q <= 1'b0;
      addr_cnt    <= 4'd0;
      data_cnt    <= 4'd0;
      pend        <= 1'b0;
`ifdef EARLY_BURST_TERM_EN
      restart     <= 1'b0;
`endif
    end else begin
      beat_done_q <= complete;
      xfer_done_q <= complete && (data_cnt == last_r);
      if (complete) begin
        beat_idx_q <= data_cnt;
        data_cnt   <= data_cnt + 4'd1;
      end
      pend <= accept || (pend && bus.hwait);

      case (state)
        S_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            addr_r      <= bus.cmd_addr;
            write_r     <= bus.cmd_write;
            size_r      <= bus.cmd_size;
            burst_r     <= bus.cmd_burst;
            last_r      <= last_beat(bus.cmd_burst, bus.cmd_len);
            cmd_ready_q <= 1'b0;
            hreq_q      <= 1'b1;
            addr_cnt    <= 4'd0;
            data_cnt    <= 4'd0;
`ifdef EARLY_BURST_TERM_EN
            restart     <= 1'b0;
`endif
            state       <= S_REQ;
          end
        end

        S_REQ: begin
          if (bus.hgrant) begin
            htrans_q <= HT_NONSEQ;
            state    <= S_ADDR;
`ifdef EARLY_BURST_TERM_EN
            if (restart) begin
              // haddr still holds the first unsent beat; the remainder goes out as INCR.
              hburst_q <= HB_INCR;
            end else begin
              haddr_q  <= addr_r;
              hwrite_q <= write_r;
              hsize_q  <= size_r;
              hburst_q <= burst_r;
            end
`else
            haddr_q  <= addr_r;
            hwrite_q <= write_r;
            hsize_q  <= size_r;
            hburst_q <= burst_r;
`endif
          end
        end

        S_ADDR: begin
          if (bus.hgrant) begin
            if (addr_cnt == last_r) begin
              htrans_q <= HT_IDLE;
              hreq_q   <= 1'b0;
              state    <= S_DRAIN;
            end else begin
              haddr_q  <= next_addr(haddr_q, hsize_q, hburst_q);
              htrans_q <= HT_SEQ;
              addr_cnt <= addr_cnt + 4'd1;
            end
          end
`ifdef EARLY_BURST_TERM_EN
          else if (!bus.hwait && (addr_cnt != 4'd0)) begin
            htrans_q <= HT_IDLE;
            restart  <= 1'b1;
            state    <= S_REQ;
          end
`endif
        end

        S_DRAIN: begin
          if (complete && (data_cnt == last_r)) begin
            cmd_ready_q <= 1'b1;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.hreq      = hreq_q;
  assign bus.htrans    = htrans_q;
  assign bus.haddr     = haddr_q;
  assign bus.hwrite    = hwrite_q;
  assign bus.hsize     = hsize_q;
  assign bus.hburst    = hburst_q;
  assign bus.beat_done = beat_done_q;
  assign bus.beat_idx  = beat_idx_q;
  assign bus.xfer_done = xfer_done_q;

endmodule
